// File: rtl/pixel_packer_pkg.sv
// Shared types and helpers for the pixel-to-AXI-Stream packer.
package pixel_packer_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DRAIN} state_t;

    localparam int PIX_W        = 16;
    localparam int AXIS_W       = 64;
    localparam int PIX_PER_BEAT = AXIS_W / PIX_W;
    localparam int KEEP_W       = AXIS_W / 8;
    localparam int BEAT_W       = AXIS_W + KEEP_W + 1;

    // Byte enables for a beat carrying n valid pixels (1..4).
    function automatic logic [7:0] keep_for_count(input logic [2:0] n);
        case (n)
            3'd1:    return 8'h03;
            3'd2:    return 8'h0F;
            3'd3:    return 8'h3F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// First-word-fall-through beat FIFO: head entry is visible whenever empty is low.
module axis_beat_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pixel_axis_packer.sv
// Packs 16-bit camera pixels into 64-bit AXI-Stream beats for the S2MM DMA.
// Define PACKER_TEST_PATTERN_EN to add the test_mode pixel-index pattern input.
//
//   state  | meaning
//   IDLE   | waiting for a capture with non-zero dimensions
//   ARMED  | frame armed, waiting for a pixel flagged pix_sof
//   STREAM | accepting pixels until the Nth or a timeout
//   DRAIN  | flushing the held tlast beat and the FIFO to the DMA
module pixel_axis_packer
    import pixel_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 512
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              capture,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic [31:0]       timeout,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
`ifdef PACKER_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err,
    output logic [31:0]       xfer_cnt
);
    state_t             state;
    logic [31:0]        n_total;
    logic [31:0]        pix_cnt;
    logic [31:0]        tmr;
    logic [AXIS_W-1:0]  part_data;
    logic [1:0]         part_cnt;
    logic               hold_valid;
    logic               hold_last;
    logic [AXIS_W-1:0]  hold_data;
    logic [KEEP_W-1:0]  hold_keep;
    logic [PIX_W-1:0]   pix_val;

    logic cap_ok, accept, last_pix, to_fire, beat_full, pad_beat, new_beat;
    logic wr_en, fifo_full, fifo_empty;
    logic [AXIS_W-1:0] nb_data;
    logic [KEEP_W-1:0] nb_keep;
    logic [BEAT_W-1:0] fifo_out;

`ifdef PACKER_TEST_PATTERN_EN
    logic tm_q;
    assign pix_val = tm_q ? pix_cnt[PIX_W-1:0] : pix_data;
`else
    assign pix_val = pix_data;
`endif

    assign cap_ok    = capture && (state == IDLE) && (img_width != 16'd0) && (img_height != 16'd0);
    assign accept    = pix_valid && (((state == ARMED) && pix_sof) || (state == STREAM));
    assign last_pix  = (pix_cnt + 32'd1) == n_total;
    assign to_fire   = ((state == ARMED) || (state == STREAM)) && !accept
                       && (timeout != 32'd0) && (tmr == 32'd0);
    assign beat_full = accept && ((part_cnt == 2'd3) || last_pix);
    assign pad_beat  = to_fire && (state == STREAM) && (part_cnt != 2'd0);
    assign new_beat  = beat_full || pad_beat;

    always_comb begin
        nb_data = part_data;
        if (accept) begin
            nb_data[{part_cnt, 4'b0000} +: PIX_W] = pix_val;
        end
        nb_keep = keep_for_count(pad_beat ? {1'b0, part_cnt} : ({1'b0, part_cnt} + 3'd1));
    end

    // The held beat leaves only once its tlast status is known; a tlast beat waits for space.
    assign wr_en = hold_valid && !fifo_full && (new_beat || (hold_last && (state == DRAIN)));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            n_total     <= '0;
            pix_cnt     <= '0;
            tmr         <= '0;
            part_data   <= '0;
            part_cnt    <= '0;
            hold_valid  <= 1'b0;
            hold_last   <= 1'b0;
            hold_data   <= '0;
            hold_keep   <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            xfer_cnt    <= '0;
`ifdef PACKER_TEST_PATTERN_EN
            tm_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (cap_ok) begin
                    state       <= ARMED;
                    n_total     <= 32'(img_width) * 32'(img_height);
                    pix_cnt     <= '0;
                    part_data   <= '0;
                    part_cnt    <= '0;
                    overflow    <= 1'b0;
                    timeout_err <= 1'b0;
`ifdef PACKER_TEST_PATTERN_EN
                    tm_q        <= test_mode;
`endif
                end
                ARMED: if (accept) begin
                    state <= last_pix ? DRAIN : STREAM;
                end else if (to_fire) begin
                    state       <= IDLE;
                    timeout_err <= 1'b1;
                end
                STREAM: if (accept && last_pix) begin
                    state <= DRAIN;
                end else if (to_fire) begin
                    state       <= DRAIN;
                    timeout_err <= 1'b1;
                end
                DRAIN: if (!hold_valid && fifo_empty) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (cap_ok || accept) begin
                tmr <= timeout;
            end else if (((state == ARMED) || (state == STREAM)) && (tmr != 32'd0)) begin
                tmr <= tmr - 32'd1;
            end

            if (accept) begin
                pix_cnt <= pix_cnt + 32'd1;
            end
            if (new_beat) begin
                part_data <= '0;
                part_cnt  <= '0;
            end else if (accept) begin
                part_data <= nb_data;
                part_cnt  <= part_cnt + 2'd1;
            end

            if (new_beat) begin
                hold_valid <= 1'b1;
                hold_data  <= nb_data;
                hold_keep  <= nb_keep;
                hold_last  <= pad_beat || last_pix;
                if (hold_valid && fifo_full) begin
                    overflow <= 1'b1;
                end
            end else if (to_fire && (state == STREAM)) begin
                hold_last <= 1'b1;
            end else if (wr_en) begin
                hold_valid <= 1'b0;
            end

            if (cap_ok) begin
                xfer_cnt <= '0;
            end else if (m_axis_tvalid && m_axis_tready) begin
                xfer_cnt <= xfer_cnt + {28'd0, keep_bytes(m_axis_tkeep)};
            end
        end
    end

    axis_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (wr_en),
        .wr_data ({hold_last, hold_keep, hold_data}),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy          = (state != IDLE);
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_out[AXIS_W-1:0];
    assign m_axis_tkeep  = fifo_empty ? '0 : fifo_out[AXIS_W +: KEEP_W];
    assign m_axis_tlast  = !fifo_empty && fifo_out[BEAT_W-1];

endmodule

// File: tb/tb_pixel_axis_packer.sv
// Directed bench for pixel_axis_packer; beats are captured on handshake and checked against hand-computed values.
module tb_pixel_axis_packer;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        capture = 1'b0;
    logic [15:0] img_width = '0;
    logic [15:0] img_height = '0;
    logic [31:0] timeout = '0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        test_mode = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic [31:0] xfer_cnt;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] bd[$];
    logic [7:0]  bk[$];
    logic        bl[$];

    pixel_axis_packer #(.FIFO_DEPTH(16)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .capture       (capture),
        .img_width     (img_width),
        .img_height    (img_height),
        .timeout       (timeout),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
`ifdef PACKER_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .xfer_cnt      (xfer_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change just after posedge, so values seen at negedge are those taken at the next posedge.
    always @(negedge sys_clk) begin
        if (!sys_rst && m_axis_tvalid && m_axis_tready) begin
            bd.push_back(m_axis_tdata);
            bk.push_back(m_axis_tkeep);
            bl.push_back(m_axis_tlast);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic cap(input logic [15:0] w, input logic [15:0] h);
        capture    = 1'b1;
        img_width  = w;
        img_height = h;
        cyc(1);
        capture    = 1'b0;
    endtask

    task automatic pix(input logic [15:0] v, input logic sof);
        pix_valid = 1'b1;
        pix_data  = v;
        pix_sof   = sof;
        cyc(1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic frame_pix(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pix(16'(base + i), i == 0);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            cyc(1);
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic clear_beats();
        bd.delete();
        bk.delete();
        bl.delete();
    endtask

    function automatic logic [63:0] beat_d(input int i);
        return (i < bd.size()) ? bd[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [7:0] beat_k(input int i);
        return (i < bk.size()) ? bk[i] : 8'h5A;
    endfunction

    function automatic logic [63:0] last_mask();
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < bl.size() && i < 64; i++) begin
            m[i] = bl[i];
        end
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        cyc(3);
        sys_rst = 1'b0;
        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_ovf",    {63'd0, overflow}, 64'd0);
        check("rst_terr",   {63'd0, timeout_err}, 64'd0);
        check("rst_xfer",   {32'd0, xfer_cnt}, 64'd0);

        // 8x2 frame with junk before sof, a stray sof mid-frame and a pixel past the end
        m_axis_tready = 1'b1;
        cap(8, 2);
        check("t1_busy", {63'd0, busy}, 64'd1);
        pix(16'hAAAA, 1'b0);
        pix(16'hBBBB, 1'b0);
        for (int i = 0; i < 16; i++) pix(16'(i), (i == 0) || (i == 8));
        pix(16'hCCCC, 1'b0);
        wait_idle("t1_idle");
        check("t1_nbeats", 64'(bd.size()), 64'd4);
        check("t1_beat0",  beat_d(0), 64'h0003_0002_0001_0000);
        check("t1_beat2",  beat_d(2), 64'h000B_000A_0009_0008);
        check("t1_beat3",  beat_d(3), 64'h000F_000E_000D_000C);
        check("t1_keep3",  {56'd0, beat_k(3)}, 64'hFF);
        check("t1_last",   last_mask(), 64'b1000);
        check("t1_xfer",   {32'd0, xfer_cnt}, 64'd32);

        // 5x1 frame: single-pixel final beat
        clear_beats();
        cap(5, 1);
        frame_pix(5, 0);
        wait_idle("t2_idle");
        check("t2_nbeats", 64'(bd.size()), 64'd2);
        check("t2_beat0",  beat_d(0), 64'h0003_0002_0001_0000);
        check("t2_beat1",  beat_d(1), 64'h0000_0000_0000_0004);
        check("t2_keep1",  {56'd0, beat_k(1)}, 64'h03);
        check("t2_last",   last_mask(), 64'b10);
        check("t2_xfer",   {32'd0, xfer_cnt}, 64'd10);

        // timeout=50, 8x8 frame stalls after 6 pixels
        clear_beats();
        timeout = 32'd50;
        cap(8, 8);
        frame_pix(6, 0);
        cyc(50);
        check("t3_terr_early", {63'd0, timeout_err}, 64'd0);
        cyc(1);
        check("t3_terr", {63'd0, timeout_err}, 64'd1);
        wait_idle("t3_idle");
        timeout = 32'd0;
        check("t3_nbeats", 64'(bd.size()), 64'd2);
        check("t3_keep0",  {56'd0, beat_k(0)}, 64'hFF);
        check("t3_keep1",  {56'd0, beat_k(1)}, 64'h0F);
        check("t3_beat1",  beat_d(1), 64'h0000_0000_0005_0004);
        check("t3_last",   last_mask(), 64'b10);
        check("t3_xfer",   {32'd0, xfer_cnt}, 64'd12);

        // 100x1 frame into a 16-deep FIFO with the DMA stalled
        clear_beats();
        m_axis_tready = 1'b0;
        cap(100, 1);
        check("t4_terr_clr", {63'd0, timeout_err}, 64'd0);
        frame_pix(100, 0);
        cyc(3);
        check("t4_ovf",    {63'd0, overflow}, 64'd1);
        check("t4_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("t4_nohs",   64'(bd.size()), 64'd0);
        m_axis_tready = 1'b1;
        wait_idle("t4_idle");
        check("t4_nbeats", 64'(bd.size()), 64'd17);
        check("t4_beat0",  beat_d(0), 64'h0003_0002_0001_0000);
        check("t4_beat15", beat_d(15), 64'h003F_003E_003D_003C);
        check("t4_beat16", beat_d(16), 64'h0063_0062_0061_0060);
        check("t4_keep16", {56'd0, beat_k(16)}, 64'hFF);
        check("t4_last",   last_mask(), 64'h1_0000);
        check("t4_xfer",   {32'd0, xfer_cnt}, 64'd136);

        // zero dimensions ignored; capture during a frame ignored
        clear_beats();
        cap(8, 0);
        check("t5_h0_busy", {63'd0, busy}, 64'd0);
        cap(0, 3);
        check("t5_w0_busy", {63'd0, busy}, 64'd0);
        cyc(5);
        check("t5_h0_beats", 64'(bd.size()), 64'd0);
        check("t5_ovf_kept", {63'd0, overflow}, 64'd1);
        cap(4, 1);
        cap(8, 8);
        frame_pix(4, 32);
        wait_idle("t5_idle");
        check("t5_nbeats", 64'(bd.size()), 64'd1);
        check("t5_beat0",  beat_d(0), 64'h0023_0022_0021_0020);
        check("t5_last",   last_mask(), 64'b1);
        check("t5_xfer",   {32'd0, xfer_cnt}, 64'd8);

        // reset mid-frame, then a clean 4x1 frame
        clear_beats();
        cap(8, 8);
        frame_pix(8, 0);
        cyc(2);
        check("t6_xfer_pre", {32'd0, xfer_cnt}, 64'd8);
        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        check("t6_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("t6_busy",   {63'd0, busy}, 64'd0);
        check("t6_xfer",   {32'd0, xfer_cnt}, 64'd0);
        clear_beats();
        cyc(3);
        check("t6_nostale", 64'(bd.size()), 64'd0);
        test_mode = 1'b1;
        cap(4, 1);
        test_mode = 1'b0;
        frame_pix(4, 16);
        wait_idle("t6_idle");
        check("t6_nbeats", 64'(bd.size()), 64'd1);
`ifdef PACKER_TEST_PATTERN_EN
        check("t6_beat0", beat_d(0), 64'h0003_0002_0001_0000);
`else
        check("t6_beat0", beat_d(0), 64'h0013_0012_0011_0010);
`endif
        check("t6_last",   last_mask(), 64'b1);
        check("t6_xfer2",  {32'd0, xfer_cnt}, 64'd8);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
